// File: rtl/demux1to2_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer.
// Holds the select encoding (same as the 2:1 selector: SEL_A picks path a /
// output 0, SEL_B picks path b / output 1), default sizes and a width helper.
package demux1to2_buf_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 2;

  // Occupancy counter width: one extra bit so full and empty are distinct.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux1to2_buf_if.sv
// Stream bundle between one producer, the demux and two consumers.
// Ports: in_valid/in_ready/in_data/in_sel (producer side), outk_valid/
// outk_ready/outk_data and cntk occupancy (consumer side, k = 0,1).
interface demux1to2_buf_if #(
  parameter int WIDTH = demux1to2_buf_pkg::DATA_W,
  parameter int DEPTH = demux1to2_buf_pkg::DEPTH_DEF
) ();
  import demux1to2_buf_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [CW-1:0]    cnt0;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    cnt1;

  // Environment side: drives the producer inputs and consumer readies.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, cnt0, out1_valid, out1_data, cnt1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, cnt0, out1_valid, out1_data, cnt1
  );

endinterface

// File: rtl/demux1to2_buf_fifo.sv
// Per-output FIFO of the demux: circular buffer with read/write pointers.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head_data,
// head_valid, count. Head is visible the cycle after the push edge.
module demux_fifo
  import demux1to2_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    head_valid,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_en;

  // The top only pops a valid head; gating again keeps an empty pop harmless.
  assign pop_en = pop && head_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so head_data reads zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);

endmodule

// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 stream demux: each accepted word goes to output 0 or 1 by in_sel.
// Ports: clk, reset (sync, active-high) and the slave side of demux1to2_buf_if.
// in_ready depends only on in_sel and the registered counts, never on outk_ready.
module demux1to2_buf
  import demux1to2_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  demux1to2_buf_if.slave  bus
);

  localparam int            CW   = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          accept_ok;
  logic          accept;
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;
  logic          head_valid0;
  logic          head_valid1;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;

  // A full FIFO refuses even when its consumer pops this cycle, so there is
  // no combinational path from out*_ready to in_ready.
  assign accept_ok = !reset && ((bus.in_sel == SEL_B) ? (count1 < FULL)
                                                      : (count0 < FULL));
  assign accept    = bus.in_valid && accept_ok;

  assign push0 = accept && (bus.in_sel == SEL_A);
  assign push1 = accept && (bus.in_sel == SEL_B);
  assign pop0  = head_valid0 && bus.out0_ready;
  assign pop1  = head_valid1 && bus.out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk        (clk),
    .reset      (reset),
    .push       (push0),
    .push_data  (bus.in_data),
    .pop        (pop0),
    .head_data  (bus.out0_data),
    .head_valid (head_valid0),
    .count      (count0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk        (clk),
    .reset      (reset),
    .push       (push1),
    .push_data  (bus.in_data),
    .pop        (pop1),
    .head_data  (bus.out1_data),
    .head_valid (head_valid1),
    .count      (count1)
  );

  assign bus.in_ready   = accept_ok;
  assign bus.out0_valid = head_valid0;
  assign bus.out1_valid = head_valid1;
  assign bus.cnt0       = count0;
  assign bus.cnt1       = count1;

endmodule

// File: tb/tb_demux1to2_buf.sv
// Self-checking bench for demux1to2_buf: directed scenarios plus random
// traffic against per-channel queue scoreboards.
module tb_demux1to2_buf;
  import demux1to2_buf_pkg::*;

  localparam int WIDTH = DATA_W;
  localparam int DEPTH = 2;
  localparam int CW    = cnt_w(DEPTH);
  localparam int N_WORDS = 10000;
  localparam int MAX_CYC = 40000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  demux1to2_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_sel = SEL_A; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", bus.out0_valid, bus.out1_valid); end
    checks++; if (bus.cnt0 !== CW'(0) || bus.cnt1 !== CW'(0)) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.cnt0, bus.cnt1); end
    checks++; if (bus.out0_data !== '0 || bus.out1_data !== '0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.out0_data, bus.out1_data); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rdy_sel0 got=%b exp=1", bus.in_ready); end
    bus.in_sel = SEL_B;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rdy_sel1 got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b%b exp=00", bus.out0_valid, bus.out1_valid); end
  endtask

  task automatic test_route();
    next_cycle();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = SEL_A; bus.in_data = 32'hA5A5_A5A5;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_rdy0 got=%b exp=1", bus.in_ready); end
    next_cycle();
    bus.in_sel = SEL_B; bus.in_data = 32'h5A5A_5A5A;
    @(negedge clk);
    checks++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL route_out0 got=%b/%h exp=1/a5a5a5a5", bus.out0_valid, bus.out0_data); end
    checks++; if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_early got=%b exp=0", bus.out1_valid); end
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h5A5A_5A5A) begin errors++; $display("FAIL route_out1 got=%b/%h exp=1/5a5a5a5a", bus.out1_valid, bus.out1_data); end
    checks++; if (bus.out0_valid !== 1'b0 || bus.cnt0 !== CW'(0)) begin errors++; $display("FAIL route_out0_drained got=%b/%0d exp=0/0", bus.out0_valid, bus.cnt0); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(0) || bus.cnt1 !== CW'(0)) begin errors++; $display("FAIL route_cnt_end got=%0d/%0d exp=0/0", bus.cnt0, bus.cnt1); end
  endtask

  task automatic test_backpressure();
    next_cycle();
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = SEL_A; bus.in_data = 32'd1;
    next_cycle();
    bus.in_data = 32'd2;
    next_cycle();
    bus.in_data = 32'd3;
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(2)) begin errors++; $display("FAIL bp_cnt_full got=%0d exp=2", bus.cnt0); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy_full got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.in_sel = SEL_B;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_other got=%b exp=1", bus.in_ready); end
    next_cycle();
    bus.in_valid = 1'b1; bus.in_sel = SEL_A; bus.in_data = 32'd3;
    bus.out0_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out0_data !== 32'd1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop1 got=%0d/rdy%b exp=1/rdy0", bus.out0_data, bus.in_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.out0_data !== 32'd2 || bus.cnt0 !== CW'(1) || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop2 got=%0d/cnt%0d/rdy%b exp=2/cnt1/rdy1", bus.out0_data, bus.cnt0, bus.in_ready); end
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out0_data !== 32'd3 || bus.cnt0 !== CW'(1)) begin errors++; $display("FAIL bp_word3 got=%0d/cnt%0d exp=3/cnt1", bus.out0_data, bus.cnt0); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(0) || bus.out0_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0d/%b exp=0/0", bus.cnt0, bus.out0_valid); end
  endtask

  task automatic test_full_push_pop();
    next_cycle();
    bus.out0_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = SEL_A; bus.in_data = 32'h10;
    next_cycle();
    bus.in_data = 32'h11;
    next_cycle();
    bus.in_data = 32'h12;
    bus.out0_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(2) || bus.in_ready !== 1'b0) begin errors++; $display("FAIL fpp_full got=cnt%0d/rdy%b exp=cnt2/rdy0", bus.cnt0, bus.in_ready); end
    next_cycle();
    bus.out0_ready = 1'b0;
    @(negedge clk);
    // 0x12 was refused at the full edge; only the pop took effect.
    checks++; if (bus.out0_data !== 32'h11 || bus.cnt0 !== CW'(1)) begin errors++; $display("FAIL fpp_head got=%h/cnt%0d exp=11/cnt1", bus.out0_data, bus.cnt0); end
    next_cycle();
    bus.in_valid = 1'b0;
    bus.out0_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(2) || bus.out0_data !== 32'h11) begin errors++; $display("FAIL fpp_late_push got=cnt%0d/%h exp=cnt2/11", bus.cnt0, bus.out0_data); end
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(0)) begin errors++; $display("FAIL fpp_drained got=%0d exp=0", bus.cnt0); end
  endtask

  task automatic test_reset_flush();
    next_cycle();
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sel = (i < 2) ? SEL_A : SEL_B;
      bus.in_data = 32'hDEAD_0000 + 32'(i);
      next_cycle();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(2) || bus.cnt1 !== CW'(2)) begin errors++; $display("FAIL flush_pre got=%0d/%0d exp=2/2", bus.cnt0, bus.cnt1); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(0) || bus.cnt1 !== CW'(0) || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin errors++; $display("FAIL flush_post got=cnt%0d/%0d vld%b%b exp=cnt0/0 vld00", bus.cnt0, bus.cnt1, bus.out0_valid, bus.out1_valid); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle=%0d got=%b%b exp=00", i, bus.out0_valid, bus.out1_valid); end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    int   accepted;
    int   cyc;
    logic rdy_seen;
    logic exp_rdy;
    accepted = 0; cyc = 0; rdy_seen = 1'b1;
    bus.in_valid = 1'b0;
    while (accepted < N_WORDS && cyc < MAX_CYC) begin
      next_cycle();
      // Producer rule: a refused word keeps its select and data.
      if (!(bus.in_valid && !rdy_seen)) begin
        bus.in_valid = ($urandom_range(0, 4) != 0);
        bus.in_sel   = 1'($urandom_range(0, 1));
        bus.in_data  = $urandom;
      end
      bus.out0_ready = ($urandom_range(0, 3) != 0);
      bus.out1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_rdy = (bus.in_sel == SEL_B) ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy); end
      checks++; if (bus.cnt0 !== CW'(q0.size()) || bus.cnt1 !== CW'(q1.size())) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.cnt0, bus.cnt1, q0.size(), q1.size()); end
      checks++; if (bus.out0_valid !== (q0.size() != 0) || bus.out1_valid !== (q1.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b%b exp=%b%b", cyc, bus.out0_valid, bus.out1_valid, q0.size() != 0, q1.size() != 0); end
      if (q0.size() != 0) begin
        checks++; if (bus.out0_data !== q0[0]) begin errors++; $display("FAIL rnd_data0 cyc=%0d got=%h exp=%h", cyc, bus.out0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        checks++; if (bus.out1_data !== q1[0]) begin errors++; $display("FAIL rnd_data1 cyc=%0d got=%h exp=%h", cyc, bus.out1_data, q1[0]); end
      end
      rdy_seen = bus.in_ready;
      if (bus.out0_ready && q0.size() != 0) void'(q0.pop_front());
      if (bus.out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (bus.in_valid && exp_rdy) begin
        if (bus.in_sel == SEL_B) q1.push_back(bus.in_data);
        else                     q0.push_back(bus.in_data);
        accepted++;
      end
      cyc++;
    end
    checks++; if (accepted < N_WORDS) begin errors++; $display("FAIL rnd_timeout accepted=%0d exp=%0d", accepted, N_WORDS); end
    next_cycle();
    bus.in_valid = 1'b0; bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      @(negedge clk);
      if (q0.size() != 0) begin
        checks++; if (bus.out0_data !== q0[0]) begin errors++; $display("FAIL drain_data0 got=%h exp=%h", bus.out0_data, q0[0]); end
        void'(q0.pop_front());
      end
      if (q1.size() != 0) begin
        checks++; if (bus.out1_data !== q1[0]) begin errors++; $display("FAIL drain_data1 got=%h exp=%h", bus.out1_data, q1[0]); end
        void'(q1.pop_front());
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (bus.cnt0 !== CW'(0) || bus.cnt1 !== CW'(0) || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin errors++; $display("FAIL drain_end got=cnt%0d/%0d vld%b%b exp=cnt0/0 vld00", bus.cnt0, bus.cnt1, bus.out0_valid, bus.out1_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_route();
    test_backpressure();
    test_full_push_pop();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
